// File: rtl/ising_run_ctrl.sv
// Anneal-run sequencer for the Ising core: pulses the core reset, waits the anneal
// time, walks the sampler read address and streams captured phase words to the host.
module ising_run_ctrl #(
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned NUM_READS  = 4,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] num_runs,
    input  logic [31:0] anneal_cycles,
    output logic        busy,
    output logic        done,
    output logic        ising_rstn,
    output logic [31:0] rd_addr,
    input  logic [31:0] phase,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [15:0] res_run,
    output logic [7:0]  res_idx,
    output logic        res_last
);

    // state      | meaning
    // S_IDLE     | no batch, core held in reset
    // S_RST      | core reset asserted for RST_CYCLES
    // S_ANNEAL   | core released, counting anneal_cycles
    // S_READ_WAIT| waiting RD_LATENCY after rd_addr update
    // S_OUT      | captured word offered to host
    // S_DONE     | one-cycle batch completion
    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_ANNEAL,
        S_READ_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
    localparam logic [31:0] LAT_LAST = 32'(RD_LATENCY - 1);
    localparam logic [7:0]  IDX_LAST = 8'(NUM_READS - 1);

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [15:0] run_cnt, run_cnt_nxt;
    logic [7:0]  read_idx, read_idx_nxt;
    logic [15:0] runs_q, runs_q_nxt;
    logic [31:0] anneal_q, anneal_q_nxt;
    logic [31:0] addr_q, addr_q_nxt;
    logic [31:0] data_q, data_q_nxt;
    logic [15:0] run_q, run_q_nxt;
    logic [7:0]  idx_q, idx_q_nxt;
    logic        last_q, last_q_nxt;
    logic        done_q, done_q_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            run_cnt  <= '0;
            read_idx <= '0;
            runs_q   <= '0;
            anneal_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            run_q    <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            run_cnt  <= run_cnt_nxt;
            read_idx <= read_idx_nxt;
            runs_q   <= runs_q_nxt;
            anneal_q <= anneal_q_nxt;
            addr_q   <= addr_q_nxt;
            data_q   <= data_q_nxt;
            run_q    <= run_q_nxt;
            idx_q    <= idx_q_nxt;
            last_q   <= last_q_nxt;
            done_q   <= done_q_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        run_cnt_nxt  = run_cnt;
        read_idx_nxt = read_idx;
        runs_q_nxt   = runs_q;
        anneal_q_nxt = anneal_q;
        addr_q_nxt   = addr_q;
        data_q_nxt   = data_q;
        run_q_nxt    = run_q;
        idx_q_nxt    = idx_q;
        last_q_nxt   = last_q;
        done_q_nxt   = 1'b0;

        // DONE has already ended the batch; abort there would only double the done pulse
        if (abort && state != S_IDLE && state != S_DONE) begin
            state_nxt    = S_IDLE;
            done_q_nxt   = 1'b1;
            cnt_nxt      = '0;
            run_cnt_nxt  = '0;
            read_idx_nxt = '0;
            addr_q_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (num_runs != 16'd0) begin
                            runs_q_nxt   = num_runs;
                            anneal_q_nxt = anneal_cycles;
                            run_cnt_nxt  = '0;
                            cnt_nxt      = '0;
                            state_nxt    = S_RST;
                        end else begin
                            done_q_nxt = 1'b1;
                        end
                    end
                end
                S_RST: begin
                    if (cnt == RST_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = S_ANNEAL;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
                S_ANNEAL: begin
                    if (anneal_q == 32'd0 || cnt == anneal_q - 32'd1) begin
                        cnt_nxt      = '0;
                        addr_q_nxt   = '0;
                        read_idx_nxt = '0;
                        state_nxt    = S_READ_WAIT;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
                S_READ_WAIT: begin
                    if (cnt == LAT_LAST) begin
                        cnt_nxt    = '0;
                        data_q_nxt = phase;
                        run_q_nxt  = run_cnt;
                        idx_q_nxt  = read_idx;
                        last_q_nxt = (run_cnt == runs_q - 16'd1) && (read_idx == IDX_LAST);
                        state_nxt  = S_OUT;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        if (read_idx < IDX_LAST) begin
                            read_idx_nxt = read_idx + 8'd1;
                            addr_q_nxt   = addr_q + 32'd1;
                            cnt_nxt      = '0;
                            state_nxt    = S_READ_WAIT;
                        end else if (run_cnt < runs_q - 16'd1) begin
                            run_cnt_nxt = run_cnt + 16'd1;
                            cnt_nxt     = '0;
                            state_nxt   = S_RST;
                        end else begin
                            done_q_nxt = 1'b1;
                            state_nxt  = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    addr_q_nxt = '0;
                    state_nxt  = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign busy       = (state == S_RST) || (state == S_ANNEAL) ||
                        (state == S_READ_WAIT) || (state == S_OUT);
    assign ising_rstn = (state == S_ANNEAL) || (state == S_READ_WAIT) || (state == S_OUT);
    assign res_valid  = (state == S_OUT);
    assign done       = done_q;
    assign rd_addr    = addr_q;
    assign res_data   = data_q;
    assign res_run    = run_q;
    assign res_idx    = idx_q;
    assign res_last   = last_q;

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Self-checking bench for ising_run_ctrl: directed and randomized batches checked
// against an expected word list and timing rules derived from the run sequence.
module tb_ising_run_ctrl;

    localparam int RST_CYCLES = 4;
    localparam int NUM_READS  = 4;
    localparam int RD_LATENCY = 1;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] num_runs = '0;
    logic [31:0] anneal_cycles = '0;
    logic        busy, done, ising_rstn, res_valid, res_last;
    logic [31:0] rd_addr, phase, res_data;
    logic        res_ready = 1'b0;
    logic [15:0] res_run;
    logic [7:0]  res_idx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [15:0] run;
        logic [7:0]  idx;
        logic        last;
    } word_t;

    word_t exp_q[$];

    ising_run_ctrl #(
        .RST_CYCLES(RST_CYCLES),
        .NUM_READS (NUM_READS),
        .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .abort        (abort),
        .num_runs     (num_runs),
        .anneal_cycles(anneal_cycles),
        .busy         (busy),
        .done         (done),
        .ising_rstn   (ising_rstn),
        .rd_addr      (rd_addr),
        .phase        (phase),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_run      (res_run),
        .res_idx      (res_idx),
        .res_last     (res_last)
    );

    // Sampler stand-in: data is a pure function of the address
    assign phase = 32'hA000 | rd_addr;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode: 0 ready high, 1 stall 20 cycles on word 2, 2 random ready, 3 random ready + stray start
    task automatic run_batch(input int nr, input int an, input int mode, input int abort_run);
        int t, rises, rise_t, low_cnt, words, stall, abort_t, n_exp, quiet;
        logic prev_rstn, prev_valid, r, finished, injected;
        logic [31:0] hold_data, hold_addr;
        exp_q.delete();
        for (int rr = 0; rr < nr; rr++)
            for (int i = 0; i < NUM_READS; i++)
                exp_q.push_back('{data: 32'hA000 | 32'(i), run: 16'(rr), idx: 8'(i),
                                  last: (rr == nr - 1) && (i == NUM_READS - 1)});
        n_exp = (abort_run >= 0) ? abort_run * NUM_READS : nr * NUM_READS;
        num_runs = 16'(nr);
        anneal_cycles = 32'(an);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("rstn_low_in_rst", ising_rstn, 0);
        t = 1; rises = 0; rise_t = 0; low_cnt = 0; words = 0; stall = 0; abort_t = -10;
        prev_rstn = 1'b0; prev_valid = 1'b0; finished = 1'b0; injected = 1'b0;
        hold_data = '0; hold_addr = '0;
        while (!finished && t < 3000) begin
            if (ising_rstn && !prev_rstn) begin
                if (rises == 0) chk("first_rise_latency", t, 1 + RST_CYCLES);
                else            chk("rst_low_len", low_cnt, RST_CYCLES);
                rises++;
                rise_t = t;
                low_cnt = 0;
            end
            if (!ising_rstn) low_cnt++;
            if (res_valid && !prev_valid && (words % NUM_READS) == 0)
                chk("anneal_gap", t - rise_t, ((an == 0) ? 1 : an) + RD_LATENCY);
            if (res_valid && prev_valid) begin
                chk("stall_data_stable", res_data, hold_data);
                chk("stall_addr_stable", rd_addr, hold_addr);
            end
            hold_data = res_data;
            hold_addr = rd_addr;
            if (done) begin
                chk("words_at_done", words, n_exp);
                chk("busy_at_done", busy, 0);
                chk("rstn_at_done", ising_rstn, 0);
                chk("valid_at_done", res_valid, 0);
                if (abort_run >= 0) chk("abort_latency", t, abort_t + 1);
                finished = 1'b1;
            end else begin
                if (abort_run >= 0 && rises == abort_run + 1 && t == rise_t + 2) begin
                    abort = 1'b1;
                    abort_t = t;
                end
                if (mode == 3 && !injected && prev_valid && !res_valid && (words % NUM_READS) != 0) begin
                    start = 1'b1;
                    num_runs = 16'd7;
                    injected = 1'b1;
                end
                case (mode)
                    1:       r = !(words == 2 && stall < 20);
                    2, 3:    r = ($urandom_range(0, 2) != 0);
                    default: r = 1'b1;
                endcase
                if (mode == 1 && res_valid && words == 2 && stall < 20) stall++;
                res_ready = r;
                if (res_valid && r && !abort) begin
                    chk("extra_word", (words < exp_q.size()) ? 1 : 0, 1);
                    if (words < exp_q.size()) begin
                        chk("res_data", res_data, exp_q[words].data);
                        chk("res_run", res_run, exp_q[words].run);
                        chk("res_idx", res_idx, exp_q[words].idx);
                        chk("res_last", res_last, exp_q[words].last);
                    end
                    words++;
                end
            end
            prev_rstn = ising_rstn;
            prev_valid = res_valid;
            if (!finished) begin
                tick;
                t++;
                start = 1'b0;
                abort = 1'b0;
                num_runs = 16'(nr);
            end
        end
        chk("batch_finished", finished, 1);
        if (mode == 1) chk("stall_cycles", stall, 20);
        res_ready = 1'b0;
        tick;
        chk("done_one_pulse", done, 0);
        quiet = 0;
        for (int k = 0; k < 6; k++) begin
            if (busy || done || res_valid || ising_rstn) quiet++;
            tick;
        end
        chk("idle_after_batch", quiet, 0);
    endtask

    initial begin
        int bound;
        rstn = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ising_rstn", ising_rstn, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_payload", {res_data, res_run, res_idx, res_last}, 0);
        tick;
        tick;
        rstn = 1'b1;
        tick;

        run_batch(2, 10, 0, -1);
        run_batch(2, 5, 1, -1);

        num_runs = 16'd0;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("zero_runs_done", done, 1);
        chk("zero_runs_busy", busy, 0);
        chk("zero_runs_rstn", ising_rstn, 0);
        tick;
        chk("zero_runs_done_end", done, 0);
        chk("zero_runs_busy_end", busy, 0);

        num_runs = 16'd2;
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_done", done, 0);
        tick;
        chk("idle_abort_busy2", busy, 0);

        run_batch(3, 10, 0, 1);
        run_batch(2, 3, 3, -1);
        run_batch(1, 0, 0, -1);
        repeat (6) run_batch(int'($urandom_range(1, 3)), int'($urandom_range(0, 12)), 2, -1);

        num_runs = 16'd1;
        anneal_cycles = 32'd2;
        res_ready = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        bound = 0;
        while (!res_valid && bound < 50) begin
            tick;
            bound++;
        end
        chk("reach_out", res_valid, 1);
        chk("out_data", res_data, 32'hA000);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_rstn", ising_rstn, 0);
        chk("async_valid", res_valid, 0);
        chk("async_done", done, 0);
        chk("async_rd_addr", rd_addr, 0);
        chk("async_payload", {res_data, res_run, res_idx, res_last}, 0);
        tick;
        rstn = 1'b1;
        tick;
        chk("post_reset_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ising_run_ctrl.md
Name: ising_run_ctrl

Overview:
- Sequences repeated anneal runs of the Ising core (oscillator matrix plus sampler).
- Per run: holds `ising_rstn` low for a fixed interval, releases it, waits a programmable anneal time, then walks the sampler read address across `NUM_READS` phase words.
- Streams each phase word out through a valid/ready interface for host-side energy evaluation.
- Sits between the host register bank and the core, and is the sole driver of `ising_rstn` and the sampler read address.

Parameters:
- RST_CYCLES, 4, number of cycles `ising_rstn` is held low at the start of each run (must be >= 1).
- NUM_READS, 4, phase words read per run (sampler read addresses 0..NUM_READS-1, must be >= 1).
- RD_LATENCY, 1, cycles from a `rd_addr` change to valid `phase` data (must be >= 1).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; starts a batch when idle.
- abort  in  1  single-cycle pulse; terminates the batch.
- num_runs  in  16  runs per batch, sampled on an accepted start.
- anneal_cycles  in  32  cycles from `ising_rstn` release to first read, sampled on an accepted start.
- busy  out  1  batch in progress.
- done  out  1  one-cycle pulse at batch end.
- ising_rstn  out  1  reset to the core and sampler.
- rd_addr  out  32  sampler read address.
- phase  in  32  sampler read data.
- res_valid  out  1  result word valid.
- res_ready  in  1  consumer ready.
- res_data  out  32  captured phase word.
- res_run  out  16  run index of this word, 0-based.
- res_idx  out  8  read index within the run.
- res_last  out  1  last word of the last run.

Behaviour:
- Reset values (async, `rstn` low):
  - state = IDLE.
  - busy=0, done=0, ising_rstn=0, rd_addr=0, res_valid=0.
  - res_data, res_run, res_idx, res_last = 0.
  - All counters = 0.
- `ising_rstn` is 0 in IDLE and RST; it is 1 only in ANNEAL, READ_WAIT and OUT. The core therefore sits in reset when no batch is active.
- IDLE:
  - start=1 with num_runs != 0: latch num_runs and anneal_cycles, run_cnt=0, busy=1, go to RST.
  - start=1 with num_runs == 0: done pulses the next cycle, no run is performed, stay in IDLE.
- RST: hold RST_CYCLES cycles, then go to ANNEAL with cycle counter cleared.
- ANNEAL:
  - Count anneal_cycles cycles with `ising_rstn`=1.
  - anneal_cycles=0 passes straight through after one cycle.
  - Then rd_addr=0, read_idx=0, go to READ_WAIT.
- READ_WAIT:
  - Wait RD_LATENCY cycles after the rd_addr update.
  - Capture `phase` into res_data; set res_run=run_cnt, res_idx=read_idx.
  - res_last = (run_cnt==num_runs-1 && read_idx==NUM_READS-1).
  - res_valid=1, go to OUT.
- OUT:
  - res_valid is held with payload stable until res_ready=1.
  - On the valid&&ready handshake:
    - If read_idx < NUM_READS-1: increment read_idx and rd_addr, go to READ_WAIT.
    - Else if run_cnt < num_runs-1: increment run_cnt, go to RST.
    - Else: go to DONE.
  - res_valid deasserts the cycle after the handshake unless the next word is immediately valid (it never is, since RD_LATENCY >= 1).
  - `ising_rstn` stays 1 while stalled. The core keeps running; the captured word does not change.
- DONE: done=1 for one cycle, busy=0, `ising_rstn`=0, rd_addr=0, return to IDLE.
- abort, in any non-IDLE state:
  - Next cycle: state IDLE, res_valid=0, `ising_rstn`=0, busy=0, done=1 (one pulse).
  - An in-flight, unaccepted word is dropped.
  - abort takes priority over a simultaneous handshake.
- start while busy is ignored. start and abort together in IDLE: abort wins and nothing starts; no done pulse.
- Counters are 32-bit; anneal compare is `cnt == anneal_cycles-1`. No wrap occurs, since the maximum count is 2^32-1.
- Latency: start to the first `ising_rstn` rise = 1 + RST_CYCLES cycles.
- Reset mid-operation: immediate return to reset values; no done pulse.

Test Plan:
- num_runs=2, anneal_cycles=10, res_ready=1, phase=0xA000|rd_addr:
  - Exactly 8 words: res_run 0,0,0,0,1,1,1,1; res_idx 0..3 twice; res_data 0xA000..0xA003.
  - res_last only on the 8th word; `ising_rstn` low for 4 cycles before each run; one done pulse.
- Backpressure: res_ready held 0 for 20 cycles on word 2 → res_valid, res_data and rd_addr stable throughout; no word lost or duplicated after release.
- num_runs=0 start → done pulses, busy never asserts, `ising_rstn` stays 0.
- abort asserted in ANNEAL of run 1 of 3 → the next cycle has busy=0, `ising_rstn`=0, done=1, and no further res_valid.
- start pulsed during READ_WAIT → ignored; word count unchanged.
- anneal_cycles=0 → first read begins 1 cycle after `ising_rstn` rise. rstn asserted mid-OUT → all outputs return to reset values asynchronously.
